wb_rr_arbiter: RTL

Two-master Wishbone B3 classic arbiter that shares the single SoC Wishbone slave bus (bootrom, RAM, UART, GPIO decode) between the vscale core data port (master 0) and a secondary master such as a debug loader or DMA (master 1). Grants are round-robin and held for the whole `cyc` tenure. A per-access watchdog terminates stalled slave accesses with a synthesized `err` so a missing slave cannot hang the CPU.

---
 rtl/wb_rr_arbiter_if.sv | 39 +++
 rtl/wb_rr_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter_if.sv
// Two-master Wishbone B3 classic arbiter bundle: both master ports, the shared slave port and the grant.
// The slave modport is the arbiter's view; the master modport is the view of whoever drives the masters.
interface wb_rr_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   m0_adr, m1_adr;
  logic [DW-1:0]   m0_dat_w, m1_dat_w;
  logic [DW/8-1:0] m0_sel, m1_sel;
  logic            m0_we, m1_we;
  logic            m0_cyc, m1_cyc;
  logic            m0_stb, m1_stb;
  logic [DW-1:0]   m0_dat_r, m1_dat_r;
  logic            m0_ack, m1_ack;
  logic            m0_err, m1_err;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_w;
  logic [DW/8-1:0] s_sel;
  logic            s_we, s_cyc, s_stb;
  logic [DW-1:0]   s_dat_r;
  logic            s_ack, s_err;
  logic [1:0]      grant;

  modport slave (
    input  m0_adr, m1_adr, m0_dat_w, m1_dat_w, m0_sel, m1_sel,
           m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb,
           s_dat_r, s_ack, s_err,
    output m0_dat_r, m1_dat_r, m0_ack, m1_ack, m0_err, m1_err,
           s_adr, s_dat_w, s_sel, s_we, s_cyc, s_stb, grant
  );

  modport master (
    output m0_adr, m1_adr, m0_dat_w, m1_dat_w, m0_sel, m1_sel,
           m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb,
           s_dat_r, s_ack, s_err,
    input  m0_dat_r, m1_dat_r, m0_ack, m1_ack, m0_err, m1_err,
           s_adr, s_dat_w, s_sel, s_we, s_cyc, s_stb, grant
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter for two Wishbone masters onto one slave bus, grant held for the whole cyc tenure.
// One request cycle from IDLE, zero-cycle handoff; ack/err/dat_r pass through combinationally, stalls end in a watchdog err.
module wb_rr_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic           clock,
  input  logic           reset_n,
  wb_rr_arbiter_if.slave bus
);
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   wd_cnt_q, wd_cnt_d;
  logic            wd_err_q, wd_err_d;
  logic            gnt0, gnt1;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_w;
  logic [DW/8-1:0] s_sel;
  logic            s_stb;

  assign gnt0 = (state_q == OWN0);
  assign gnt1 = (state_q == OWN1);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (bus.m0_cyc && bus.m1_cyc) state_d = last_q ? OWN0 : OWN1;
        else if (bus.m0_cyc)          state_d = OWN0;
        else if (bus.m1_cyc)          state_d = OWN1;
      end
      OWN0: begin
        if (!bus.m0_cyc) begin
          last_d  = 1'b0;
          state_d = bus.m1_cyc ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!bus.m1_cyc) begin
          last_d  = 1'b1;
          state_d = bus.m0_cyc ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Master 0 is the default source so an idle bus shows the CPU's address.
  assign s_adr   = gnt1 ? bus.m1_adr   : bus.m0_adr;
  assign s_dat_w = gnt1 ? bus.m1_dat_w : bus.m0_dat_w;
  assign s_sel   = gnt1 ? bus.m1_sel   : bus.m0_sel;
  assign s_stb   = (bus.m0_stb & gnt0) | (bus.m1_stb & gnt1);

  assign bus.s_adr   = s_adr;
  assign bus.s_dat_w = s_dat_w;
  assign bus.s_sel   = s_sel;
  assign bus.s_we    = gnt1 ? bus.m1_we : bus.m0_we;
  assign bus.s_cyc   = (bus.m0_cyc & gnt0) | (bus.m1_cyc & gnt1);
  assign bus.s_stb   = s_stb;
  assign bus.grant   = {gnt1, gnt0};

  assign bus.m0_dat_r = bus.s_dat_r;
  assign bus.m1_dat_r = bus.s_dat_r;
  assign bus.m0_ack   = bus.s_ack & gnt0 & ~wd_err_q;
  assign bus.m1_ack   = bus.s_ack & gnt1 & ~wd_err_q;
  assign bus.m0_err   = (bus.s_err | wd_err_q) & gnt0;
  assign bus.m1_err   = (bus.s_err | wd_err_q) & gnt1;

  // The count only survives cycles where the same owner keeps stb up unanswered.
  always_comb begin
    wd_cnt_d = '0;
    wd_err_d = 1'b0;
    if (TIMEOUT != 0 && s_stb && !bus.s_ack && !bus.s_err && !wd_err_q &&
        state_d == state_q) begin
      if (wd_cnt_q == WD_LAST) wd_err_d = 1'b1;
      else                     wd_cnt_d = wd_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end
endmodule
